// File: rtl/ahb_bus_arbiter_2m.sv
// Two-master round-robin arbiter for the shared accelerator bus. Ownership moves only
// at transfer boundaries, with a bounded hold time and a one-cycle idle handover.
module ahb_bus_arbiter_2m #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  output logic        m0_gnt,
  output logic        m1_gnt,
  input  logic [31:0] m0_ADDR,
  input  logic [31:0] m1_ADDR,
  input  logic [1:0]  m0_TRANS,
  input  logic [1:0]  m1_TRANS,
  input  logic [2:0]  m0_BURST,
  input  logic [2:0]  m1_BURST,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m1_hsize,
  input  logic        m0_SEL,
  input  logic        m1_SEL,
  input  logic [3:0]  m0_PROT,
  input  logic [3:0]  m1_PROT,
  input  logic        m0_HWRITE,
  input  logic        m1_HWRITE,
  input  logic [31:0] m0_WDATA,
  input  logic [31:0] m1_WDATA,
  input  logic        m0_READY_in,
  input  logic        m1_READY_in,
  output logic [31:0] m0_RDATA,
  output logic [31:0] m1_RDATA,
  output logic        m0_READY_out,
  output logic        m1_READY_out,
  output logic        m0_RESP,
  output logic        m1_RESP,
  output logic [31:0] ADDR,
  output logic [1:0]  TRANS,
  output logic [2:0]  BURST,
  output logic [2:0]  hsize,
  output logic        SEL,
  output logic [3:0]  PROT,
  output logic        HWRITE,
  output logic [31:0] WDATA,
  output logic        READY_in,
  input  logic [31:0] RDATA,
  input  logic        READY_out,
  input  logic        RESP,
  output logic        owner,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT0   = 2'd1;
  localparam logic [1:0] ST_GRANT1   = 2'd2;
  localparam logic [1:0] ST_HANDOVER = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic [1:0] req;
  logic [1:0] boundary;
  logic [1:0] gnt_vec;
  logic       cur;
  logic       pick;
  logic       hold_expired;

  assign req          = {m1_req, m0_req};
  assign boundary     = {m1_TRANS == 2'b00, m0_TRANS == 2'b00};
  assign gnt_vec      = {state_reg == ST_GRANT1, state_reg == ST_GRANT0};
  assign cur          = gnt_vec[1];
  // On a tie the master that did not win last time goes next.
  assign pick         = (req == 2'b11) ? ~last_reg : req[1];
  assign hold_expired = hold_cnt_reg >= CNT_W'(MAX_HOLD);

  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      ST_IDLE, ST_HANDOVER: begin
        if (|req) begin
          state_next    = pick ? ST_GRANT1 : ST_GRANT0;
          last_next     = pick;
          hold_cnt_next = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        // Release is only considered while the owner is between transfers.
        if (boundary[cur] && (!req[cur] || (hold_expired && req[!cur]))) begin
          state_next = ST_HANDOVER;
        end else if (!hold_expired) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      last_reg     <= 1'b1;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign m0_gnt = gnt_vec[0];
  assign m1_gnt = gnt_vec[1];
  assign busy   = |gnt_vec;
  assign owner  = last_reg;

  always_comb begin
    ADDR     = '0;
    TRANS    = '0;
    BURST    = '0;
    hsize    = '0;
    SEL      = 1'b0;
    PROT     = '0;
    HWRITE   = 1'b0;
    WDATA    = '0;
    READY_in = 1'b0;
    if (gnt_vec[0]) begin
      ADDR     = m0_ADDR;
      TRANS    = m0_TRANS;
      BURST    = m0_BURST;
      hsize    = m0_hsize;
      SEL      = m0_SEL;
      PROT     = m0_PROT;
      HWRITE   = m0_HWRITE;
      WDATA    = m0_WDATA;
      READY_in = m0_READY_in;
    end else if (gnt_vec[1]) begin
      ADDR     = m1_ADDR;
      TRANS    = m1_TRANS;
      BURST    = m1_BURST;
      hsize    = m1_hsize;
      SEL      = m1_SEL;
      PROT     = m1_PROT;
      HWRITE   = m1_HWRITE;
      WDATA    = m1_WDATA;
      READY_in = m1_READY_in;
    end
  end

  logic [31:0] rdata_ret [2];
  logic [1:0]  ready_ret;
  logic [1:0]  resp_ret;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      assign rdata_ret[gi] = gnt_vec[gi] ? RDATA : 32'd0;
      assign ready_ret[gi] = gnt_vec[gi] & READY_out;
      assign resp_ret[gi]  = gnt_vec[gi] & RESP;
    end
  endgenerate

  assign m0_RDATA     = rdata_ret[0];
  assign m1_RDATA     = rdata_ret[1];
  assign m0_READY_out = ready_ret[0];
  assign m1_READY_out = ready_ret[1];
  assign m0_RESP      = resp_ret[0];
  assign m1_RESP      = resp_ret[1];

endmodule

// File: tb/tb_ahb_bus_arbiter_2m.sv
// Scoreboard bench for ahb_bus_arbiter_2m: a bus-ownership model predicts every output
// each cycle, a negedge monitor pops and compares.
module tb_ahb_bus_arbiter_2m;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req;
  logic [31:0] addr   [2];
  logic [1:0]  trans  [2];
  logic [2:0]  burst  [2];
  logic [2:0]  hsz    [2];
  logic [1:0]  sel;
  logic [3:0]  prot   [2];
  logic [1:0]  hwrite;
  logic [31:0] wdata  [2];
  logic [1:0]  rdy_in;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        s_resp;

  logic        m0_gnt, m1_gnt, owner, busy;
  logic [31:0] m0_RDATA, m1_RDATA, ADDR, WDATA;
  logic        m0_READY_out, m1_READY_out, m0_RESP, m1_RESP;
  logic [1:0]  TRANS;
  logic [2:0]  BURST, hsize;
  logic        SEL, HWRITE, READY_in;
  logic [3:0]  PROT;

  ahb_bus_arbiter_2m #(.MAX_HOLD(HOLD), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m1_req(req[1]), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_ADDR(addr[0]), .m1_ADDR(addr[1]), .m0_TRANS(trans[0]), .m1_TRANS(trans[1]),
    .m0_BURST(burst[0]), .m1_BURST(burst[1]), .m0_hsize(hsz[0]), .m1_hsize(hsz[1]),
    .m0_SEL(sel[0]), .m1_SEL(sel[1]), .m0_PROT(prot[0]), .m1_PROT(prot[1]),
    .m0_HWRITE(hwrite[0]), .m1_HWRITE(hwrite[1]), .m0_WDATA(wdata[0]), .m1_WDATA(wdata[1]),
    .m0_READY_in(rdy_in[0]), .m1_READY_in(rdy_in[1]),
    .m0_RDATA(m0_RDATA), .m1_RDATA(m1_RDATA),
    .m0_READY_out(m0_READY_out), .m1_READY_out(m1_READY_out),
    .m0_RESP(m0_RESP), .m1_RESP(m1_RESP),
    .ADDR(ADDR), .TRANS(TRANS), .BURST(BURST), .hsize(hsize), .SEL(SEL), .PROT(PROT),
    .HWRITE(HWRITE), .WDATA(WDATA), .READY_in(READY_in),
    .RDATA(s_rdata), .READY_out(s_ready), .RESP(s_resp),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic [1:0]  gnt;
    logic        owner;
    logic        busy;
    logic [78:0] bus;
    logic [33:0] ret0;
    logic [33:0] ret1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: who holds the bus (-1 = nobody), how long, and who won last.
  int   holder      = -1;
  int   held_cycles = 0;
  int   prev_winner = 1;

  function automatic logic [78:0] bus_of(int x);
    return {addr[x], trans[x], burst[x], hsz[x], sel[x], prot[x], hwrite[x], wdata[x], rdy_in[x]};
  endfunction

  function automatic void check(string name, logic [78:0] got, logic [78:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h expected=%h", name, got, want);
  endfunction

  task automatic push_expect();
    exp_t e;
    e.gnt   = {holder == 1, holder == 0};
    e.owner = prev_winner[0];
    e.busy  = holder >= 0;
    e.bus   = (holder >= 0) ? bus_of(holder) : 79'd0;
    e.ret0  = (holder == 0) ? {s_rdata, s_ready, s_resp} : 34'd0;
    e.ret1  = (holder == 1) ? {s_rdata, s_ready, s_resp} : 34'd0;
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    int other;
    if (reset) begin
      holder = -1; held_cycles = 0; prev_winner = 1;
    end else if (holder >= 0) begin
      other = 1 - holder;
      if (trans[holder] == 2'b00 &&
          (!req[holder] || (held_cycles >= HOLD && req[other]))) begin
        holder = -1;
      end else begin
        held_cycles = (held_cycles + 1 > HOLD) ? HOLD : held_cycles + 1;
      end
    end else if (req != 2'b00) begin
      // Free bus (idle or handover): tie goes to whoever did not win last.
      holder      = (req == 2'b11) ? 1 - prev_winner : (req[1] ? 1 : 0);
      prev_winner = holder;
      held_cycles = 0;
    end
  endtask

  // Present current inputs for one cycle, record prediction, then take the edge.
  task automatic cyc(int n);
    repeat (n) begin
      push_expect();
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt",    79'({m1_gnt, m0_gnt}), 79'(e.gnt));
      check("owner",  79'(owner), 79'(e.owner));
      check("busy",   79'(busy), 79'(e.busy));
      check("slave_bus", {ADDR, TRANS, BURST, hsize, SEL, PROT, HWRITE, WDATA, READY_in}, e.bus);
      check("m0_ret", 79'({m0_RDATA, m0_READY_out, m0_RESP}), 79'(e.ret0));
      check("m1_ret", 79'({m1_RDATA, m1_READY_out, m1_RESP}), 79'(e.ret1));
      $display("cycle t=%0t gnt=%b owner=%b busy=%b ADDR=%h TRANS=%b", $time,
               {m1_gnt, m0_gnt}, owner, busy, ADDR, TRANS);
    end
  end

  task automatic clear_inputs();
    req = 2'b00; sel = 2'b00; hwrite = 2'b00; rdy_in = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; trans[i] = '0; burst[i] = '0; hsz[i] = '0; prot[i] = '0; wdata[i] = '0;
    end
    s_rdata = '0; s_ready = 1'b0; s_resp = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    model_edge();
    #1;
    cyc(2);
    reset = 1'b0;

    // m0 alone: grant next cycle, read data returns to m0 only.
    req[0] = 1'b1;
    cyc(1);
    addr[0] = 32'h5000_0000; trans[0] = 2'b10; sel[0] = 1'b1; hsz[0] = 3'd2;
    rdy_in[0] = 1'b1; s_rdata = 32'h0102_0304; s_ready = 1'b1;
    cyc(2);
    trans[0] = 2'b00; req[0] = 1'b0;
    cyc(2);

    // Both from reset: m0 first, m1 after one handover cycle.
    reset = 1'b1; cyc(1); reset = 1'b0;
    req = 2'b11;
    cyc(3);
    req[0] = 1'b0;
    cyc(3);

    // m1 keeps requesting against m0: hold expiry at the next boundary.
    req[0] = 1'b1;
    trans[1] = 2'b10; addr[1] = 32'h6000_0010; sel[1] = 1'b1;
    cyc(3);
    trans[1] = 2'b00;
    cyc(4);

    // m0 drops req mid-write: grant persists until TRANS returns to idle.
    addr[0] = 32'h5000_0004; wdata[0] = 32'h0403_0201; hwrite[0] = 1'b1; trans[0] = 2'b10;
    req[0] = 1'b0;
    cyc(3);
    trans[0] = 2'b00;
    cyc(3);

    // Reset mid-transfer while m1 owns the bus.
    trans[1] = 2'b10;
    reset = 1'b1; cyc(1); reset = 1'b0;
    trans[1] = 2'b00; req = 2'b11;
    cyc(3);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int x = 0; x < 2; x++) begin
        if ($urandom_range(7) == 0) req[x] = ~req[x];
        trans[x]  = (holder == x && $urandom_range(1) == 1) ? 2'b10 : 2'b00;
        addr[x]   = $urandom;
        wdata[x]  = $urandom;
        burst[x]  = 3'($urandom);
        hsz[x]    = 3'($urandom);
        prot[x]   = 4'($urandom);
        sel[x]    = 1'($urandom);
        hwrite[x] = 1'($urandom);
        rdy_in[x] = 1'($urandom);
      end
      s_rdata = $urandom;
      s_ready = 1'($urandom);
      s_resp  = 1'($urandom);
      reset   = ($urandom_range(99) == 0);
      cyc(1);
    end
    reset = 1'b0;

    @(negedge clk);
    #1;
    check("queue_drain", 79'(exp_q.size()), 79'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
